// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and prescale
// width, common to the transmit and receive paths.
package uart_pkg;

    localparam int unsigned PRESCALE_W = 6;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_core_if.sv
// Parallel-side request bundle plus serial-line outputs of the UART transmitter.
interface uart_tx_core_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    import uart_pkg::*;

    logic [PRESCALE_W-1:0] prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  TX_OUT;
    logic                  busy;

    modport master (
        output prescale, PAR_EN, PAR_TYP, P_DATA, DATA_VALID,
        input  TX_OUT, busy
    );

    modport slave (
        input  prescale, PAR_EN, PAR_TYP, P_DATA, DATA_VALID,
        output TX_OUT, busy
    );

endinterface

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity of the latched transmit word (even or odd selectable).
module uart_tx_parity_calc
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);

    // Even parity makes the total count of ones even; odd makes it odd.
    always_comb begin
        parity = (par_typ == PAR_ODD) ? ~^data : ^data;
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: accepts a word when idle, then shifts out start, data
// (LSB first), optional parity and stop bits, each held for prescale clocks.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_core_if.slave  tx_if
);

    localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PRESCALE_W-1:0] PRESC_ONE = PRESCALE_W'(1);
    localparam logic [BIT_W-1:0]      BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]      BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_d;
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic                  parity_bit;
    logic                  bit_last;
    logic [BIT_W-1:0]      bit_nxt;

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (data_q),
        .par_typ (par_typ_q),
        .parity  (parity_bit)
    );

    // End of the current bit period; a latched prescale of 0 behaves as 1.
    always_comb begin
        bit_last = (presc_q == '0) || (edge_cnt_q == (presc_q - PRESC_ONE));
        bit_nxt  = bit_cnt_q + BIT_ONE;
    end

    // Next-state, counter, shadow-register and line-level computation.
    // The output value is chosen for the state being entered so TX_OUT is a flop.
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        presc_d    = presc_q;
        tx_d       = tx_q;
        busy_d     = busy_q;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_if.DATA_VALID) begin
                    data_d     = tx_if.P_DATA;
                    par_en_d   = tx_if.PAR_EN;
                    par_typ_d  = tx_if.PAR_TYP;
                    presc_d    = tx_if.prescale;
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_START: begin
                if (bit_last) begin
                    edge_cnt_d = '0;
                    state_d    = ST_DATA;
                    tx_d       = data_q[0];
                end else begin
                    edge_cnt_d = edge_cnt_q + PRESC_ONE;
                end
            end
            ST_DATA: begin
                if (bit_last) begin
                    edge_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_bit;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_nxt;
                        tx_d      = data_q[bit_nxt];
                    end
                end else begin
                    edge_cnt_d = edge_cnt_q + PRESC_ONE;
                end
            end
            ST_PARITY: begin
                if (bit_last) begin
                    edge_cnt_d = '0;
                    state_d    = ST_STOP;
                    tx_d       = 1'b1;
                end else begin
                    edge_cnt_d = edge_cnt_q + PRESC_ONE;
                end
            end
            ST_STOP: begin
                if (bit_last) begin
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_IDLE;
                    tx_d       = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    edge_cnt_d = edge_cnt_q + PRESC_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset to the idle line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            presc_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            presc_q    <= presc_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_if.TX_OUT = tx_q;
    assign tx_if.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: stimulus queues expected frames, a
// line monitor decodes TX_OUT/busy cycle by cycle and compares.
module tb_uart_tx_core;

    typedef struct {
        logic [7:0] data;
        logic       pen;
        logic       ptyp;
        int         p;
        int         gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_s = 1'b1;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];

    uart_tx_core_if #(.DATA_WIDTH(8)) tx_if ();

    uart_tx_core #(.DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .tx_if (tx_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_s <= rst;

    function automatic int eff_p(exp_t e);
        return (e.p == 0) ? 1 : e.p;
    endfunction

    function automatic int frame_bits(exp_t e);
        return e.pen ? 11 : 10;
    endfunction

    function automatic logic exp_bit(exp_t e, int idx);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(e.data[i]);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return e.data[idx-1];
        if (idx == 9 && e.pen) return ((ones % 2) == 1) ^ e.ptyp;
        return 1'b1;
    endfunction

    // Line monitor
    bit   mon_act  = 0;
    bit   have_exp = 0;
    int   mon_cyc  = 0;
    int   gap      = -1;
    exp_t cur;

    always @(negedge clk) begin
        if (rst_s) begin
            checks++;
            if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_out tx=%0b busy=%0b required tx=1 busy=0", tx_if.TX_OUT, tx_if.busy);
            end
            mon_act = 0;
            have_exp = 0;
            gap = -1;
        end else begin
            if (mon_act && !tx_if.busy) begin
                if (have_exp) begin
                    checks++;
                    if (mon_cyc != frame_bits(cur) * eff_p(cur)) begin
                        failures++;
                        $display("FAIL busy_len data=%h got=%0d required=%0d", cur.data, mon_cyc, frame_bits(cur) * eff_p(cur));
                    end
                end
                mon_act = 0;
                gap = 0;
            end
            if (!mon_act && !tx_if.busy) begin
                checks++;
                if (tx_if.TX_OUT !== 1'b1) begin
                    failures++;
                    $display("FAIL idle_line tx=%0b required=1", tx_if.TX_OUT);
                end
                if (gap >= 0) gap++;
            end else if (!mon_act && tx_if.busy) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame got=busy required=idle");
                    have_exp = 0;
                end else begin
                    cur = sb.pop_front();
                    have_exp = 1;
                    if (cur.gap >= 0) begin
                        checks++;
                        if (gap != cur.gap) begin
                            failures++;
                            $display("FAIL frame_gap data=%h got=%0d required=%0d", cur.data, gap, cur.gap);
                        end
                    end
                end
                mon_act = 1;
                mon_cyc = 0;
            end
            if (mon_act && tx_if.busy) begin
                if (have_exp) begin
                    if (mon_cyc < frame_bits(cur) * eff_p(cur)) begin
                        checks++;
                        if (tx_if.TX_OUT !== exp_bit(cur, mon_cyc / eff_p(cur))) begin
                            failures++;
                            $display("FAIL line_bit data=%h bit=%0d cyc=%0d got=%0b required=%0b",
                                     cur.data, mon_cyc / eff_p(cur), mon_cyc, tx_if.TX_OUT,
                                     exp_bit(cur, mon_cyc / eff_p(cur)));
                        end
                    end else if (mon_cyc == frame_bits(cur) * eff_p(cur)) begin
                        checks++;
                        failures++;
                        $display("FAIL busy_len data=%h got>%0d required=%0d", cur.data, mon_cyc, mon_cyc);
                    end
                end
                mon_cyc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input logic level, input string what);
        int n;
        n = 0;
        while (tx_if.busy !== level) begin
            tick();
            n++;
            if (n > 2000) begin
                checks++;
                failures++;
                $display("FAIL timeout_%s got=busy%0b required=busy%0b", what, tx_if.busy, level);
                break;
            end
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pen, input logic ptyp, input int p, input int g);
        exp_t e;
        wait_busy(1'b0, "idle");
        tx_if.P_DATA     = d;
        tx_if.PAR_EN     = pen;
        tx_if.PAR_TYP    = ptyp;
        tx_if.prescale   = 6'(p);
        tx_if.DATA_VALID = 1'b1;
        e.data = d; e.pen = pen; e.ptyp = ptyp; e.p = p; e.gap = g;
        sb.push_back(e);
        tick();
        tx_if.DATA_VALID = 1'b0;
        tx_if.P_DATA     = ~d;
        tx_if.PAR_EN     = ~pen;
        tx_if.PAR_TYP    = ~ptyp;
        tx_if.prescale   = 6'(p + 3);
    endtask

    initial begin
        exp_t e;
        int n;
        tx_if.P_DATA     = '0;
        tx_if.PAR_EN     = 1'b0;
        tx_if.PAR_TYP    = 1'b0;
        tx_if.prescale   = '0;
        tx_if.DATA_VALID = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        send(8'hA5, 1'b1, 1'b0, 1, -1);
        send(8'h01, 1'b1, 1'b1, 8, 1);
        send(8'hFF, 1'b0, 1'b0, 4, 1);

        // Request during an active frame must be dropped
        send(8'hA5, 1'b1, 1'b0, 2, 1);
        repeat (5) tick();
        tx_if.P_DATA     = 8'h3C;
        tx_if.DATA_VALID = 1'b1;
        tick();
        tx_if.DATA_VALID = 1'b0;

        // prescale 0 behaves as 1
        send(8'h96, 1'b0, 1'b1, 0, 1);

        // Reset mid-frame
        send(8'hC3, 1'b1, 1'b0, 3, 1);
        repeat (10) tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();

        // DATA_VALID held high: back-to-back frames separated by one idle cycle
        wait_busy(1'b0, "idle");
        tx_if.P_DATA   = 8'h5A;
        tx_if.PAR_EN   = 1'b0;
        tx_if.PAR_TYP  = 1'b0;
        tx_if.prescale = 6'd2;
        e.data = 8'h5A; e.pen = 1'b0; e.ptyp = 1'b0; e.p = 2;
        for (int k = 0; k < 3; k++) begin
            e.gap = (k == 0) ? -1 : 1;
            sb.push_back(e);
        end
        tx_if.DATA_VALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_busy(1'b1, "rise");
            wait_busy(1'b0, "fall");
        end
        tx_if.DATA_VALID = 1'b0;

        n = 0;
        while ((sb.size() != 0 || mon_act) && n < 500) begin
            tick();
            n++;
        end
        repeat (5) tick();
        checks++;
        if (sb.size() != 0 || mon_act) begin
            failures++;
            $display("FAIL drain pending=%0d active=%0b required pending=0 active=0", sb.size(), mon_act);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
